// File: rtl/keypad_scan_if.sv
// +----------------------------------------------------------------------+
// | keypad_scan_if : keypad pins and decoded-key outputs bundle          |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
`default_nettype none

interface keypad_scan_if;
  logic       scan_en;
  logic [3:0] rows;
  logic [3:0] cols;
  logic       key_valid;
  logic [3:0] key_code;
  logic [1:0] scan_col;

  // Master drives the keypad rows and scan enable; slave is the scanner.
  modport master (
    output scan_en,
    output rows,
    input  cols,
    input  key_valid,
    input  key_code,
    input  scan_col
  );

  modport slave (
    input  scan_en,
    input  rows,
    output cols,
    output key_valid,
    output key_code,
    output scan_col
  );
endinterface

`default_nettype wire

// File: rtl/keypad_scan_ctrl.sv
// +----------------------------------------------------------------------+
// | keypad_scan_ctrl : 4x4 matrix keypad column scanner with key lock    |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
`default_nettype none

module keypad_scan_ctrl #(
  parameter int SETTLE_BITS = 8
) (
  input  logic          clk,
  input  logic          rst,
  keypad_scan_if.slave  kp
);

  localparam logic [SETTLE_BITS-1:0] C_TC  = '1;
  localparam logic [SETTLE_BITS-1:0] C_ONE = {{(SETTLE_BITS-1){1'b0}}, 1'b1};

  typedef enum logic [0:0] {
    ST_SCAN   = 1'b0,
    ST_LOCKED = 1'b1
  } state_e;

  state_e                 state_q;
  logic [3:0]             sync1_q;
  logic [3:0]             rows_s_q;
  logic [SETTLE_BITS-1:0] cnt_q;
  logic [1:0]             col_q;
  logic [3:0]             cols_q;
  logic [1:0]             row_q;
  logic                   valid_q;
  logic [3:0]             code_q;

  logic                   single_d;
  logic [1:0]             hit_row_d;
  logic [1:0]             col_next_d;
  logic [3:0]             cols_next_d;

  function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] code;
    case ({r, c})
      4'b00_00: code = 4'h1;
      4'b00_01: code = 4'h2;
      4'b00_10: code = 4'h3;
      4'b00_11: code = 4'hA;
      4'b01_00: code = 4'h4;
      4'b01_01: code = 4'h5;
      4'b01_10: code = 4'h6;
      4'b01_11: code = 4'hB;
      4'b10_00: code = 4'h7;
      4'b10_01: code = 4'h8;
      4'b10_10: code = 4'h9;
      4'b10_11: code = 4'hC;
      4'b11_00: code = 4'hE;
      4'b11_01: code = 4'h0;
      4'b11_10: code = 4'hF;
      default:  code = 4'hD;
    endcase
    return code;
  endfunction

  // Only a pattern with exactly one low row is a lockable key; ghosting
  // or multiple presses in one column fall through to the default.
  always_comb begin
    single_d  = 1'b0;
    hit_row_d = 2'd0;
    case (rows_s_q)
      4'b1110: begin single_d = 1'b1; hit_row_d = 2'd0; end
      4'b1101: begin single_d = 1'b1; hit_row_d = 2'd1; end
      4'b1011: begin single_d = 1'b1; hit_row_d = 2'd2; end
      4'b0111: begin single_d = 1'b1; hit_row_d = 2'd3; end
      default: begin single_d = 1'b0; hit_row_d = 2'd0; end
    endcase
  end

  assign col_next_d  = col_q + 2'd1;
  assign cols_next_d = ~(4'b0001 << col_next_d);

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q  <= 4'b1111;
      rows_s_q <= 4'b1111;
      state_q  <= ST_SCAN;
      cnt_q    <= '0;
      col_q    <= 2'd0;
      cols_q   <= 4'b1110;
      row_q    <= 2'd0;
      valid_q  <= 1'b0;
      code_q   <= 4'h0;
    end else begin
      sync1_q  <= kp.rows;
      rows_s_q <= sync1_q;
      case (state_q)
        ST_SCAN: begin
          // The terminal sample is taken regardless of scan_en; the enable
          // only gates counting toward it.
          if (cnt_q == C_TC) begin
            if (single_d) begin
              state_q <= ST_LOCKED;
              row_q   <= hit_row_d;
              valid_q <= 1'b1;
              code_q  <= key_map(hit_row_d, col_q);
            end else begin
              col_q  <= col_next_d;
              cols_q <= cols_next_d;
              cnt_q  <= '0;
            end
          end else if (kp.scan_en) begin
            cnt_q <= cnt_q + C_ONE;
          end
        end
        ST_LOCKED: begin
          if (rows_s_q[row_q]) begin
            state_q <= ST_SCAN;
            valid_q <= 1'b0;
            col_q   <= col_next_d;
            cols_q  <= cols_next_d;
            cnt_q   <= '0;
          end
        end
        default: state_q <= ST_SCAN;
      endcase
    end
  end

  assign kp.cols      = cols_q;
  assign kp.key_valid = valid_q;
  assign kp.key_code  = code_q;
  assign kp.scan_col  = col_q;

endmodule

`default_nettype wire
